pc_unit: RTL
============

# pc_unit

Program-counter stage directly upstream of instruction fetch. Holds the architectural PC and presents it to the fetch stage. Advances it by 4, or to a branch/jump, trap or mret target, once per completed instruction as signalled by the fetch stage's `pc_add_en`. Requests from execute may arrive in any cycle and are latched until the next advance, so the execute stage need not align with the fetch handshake.

## Interface
- `RESET_PC`, 32'h8000_0000, PC value after reset.
- `sys_clk`  in  1  single clock; all state updates on rising edge.
- `sys_rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `pc_add_en`  in  1  advance strobe from fetch; one cycle per completed instruction.
- `redir_valid`  in  1  taken branch/jump request.
- `redir_target`  in  32  branch/jump target.
- `trap_valid`  in  1  trap entry request (ecall/exception).
- `mtvec`  in  32  trap vector base.
- `mret_valid`  in  1  return-from-trap request.
- `pc`  out  32  current PC, registered.
- `mepc`  out  32  saved trap PC, registered.
- `pend_valid`  out  1  a latched request is waiting for `pc_add_en`.
- `misalign_err`  out  1  sticky; a redirect/trap/mret target had bits [1:0] ≠ 0.
- `retire_cnt`  out  64  instructions retired (present only with `PC_UNIT_RETIRE_CNT_EN`).

## Operation
- Reset values (while `sys_rst`=0): `pc`=RESET_PC, `mepc`=0, `pend_valid`=0, `misalign_err`=0, `retire_cnt`=0.
- Request priority is trap > mret > redirect, for same-cycle inputs and for pending-vs-new comparisons.
- Pending latch holds kind (TRAP/MRET/REDIR) plus target. The target is `mtvec`, `mepc` (read at advance) or `redir_target`.
- Request in a cycle with `pc_add_en`=0:
  - latch it if `pend_valid`=0, or if its priority ≥ the pending kind;
  - otherwise drop it.
- Advance cycle (`pc_add_en`=1): select one source:
  - the same-cycle request, if any (it overrides pending, even one of higher priority);
  - else the pending request;
  - else sequential `pc+4`.
- After every advance, pending is cleared.
- Trap advance: `mepc` ← current `pc`; `pc` ← `mtvec` with [1:0] cleared.
- Mret advance: `pc` ← `mepc` with [1:0] cleared; `mepc` is unchanged.
- Redirect advance: `pc` ← `redir_target` with [1:0] cleared.
- Misalignment:
  - a selected non-sequential target with [1:0] ≠ 0 sets `misalign_err`;
  - `misalign_err` clears only on reset;
  - `pc` still takes the cleared-bits target.
- Arithmetic: `pc+4` is 32-bit modulo, so 32'hFFFF_FFFC advances to 32'h0000_0000.

## Timing
- `pc` and `mepc` change only on the edge where `pc_add_en`=1 is sampled, and are visible the next cycle.
- The fetch stage reads `pc` the cycle after it strobes `pc_add_en`.
- Request latch: `pend_valid` rises on the edge after a request with `pc_add_en`=0. It falls on the edge of the advance that consumes it.
- `pc_add_en` held high on consecutive cycles: each cycle is a separate advance.
- Zero-latency redirect: a request concurrent with `pc_add_en` takes effect at that same edge.
- Reset asserted mid-operation clears all state immediately (asynchronous). First advance after release produces RESET_PC+4 unless a request is present.

## Configuration
- `PC_UNIT_RETIRE_CNT_EN` defined:
  - 64-bit `retire_cnt` port and register exist;
  - the counter increments by 1 on every `pc_add_en` edge and wraps modulo 2^64.
- Not defined: the port and counter are omitted. All other behaviour is identical.

## Test plan
- Reset with RESET_PC default, then 3 `pc_add_en` pulses -> `pc` = 8000_0004, 8000_0008, 8000_000C; `retire_cnt`=3 when enabled.
- Redirect 8000_0100 with `pc_add_en`=0 -> `pend_valid`=1, `pc` unchanged. Next `pc_add_en` -> `pc`=8000_0100, `pend_valid`=0.
- Trap pending at `pc`=8000_0010, then same-cycle redirect 8000_0200 with `pc_add_en` -> `pc`=8000_0200 (same-cycle overrides pending), `mepc` unchanged.
- Trap with `mtvec`=8000_1000 at `pc`=8000_0020, advance -> `pc`=8000_1000, `mepc`=8000_0020. Mret + advance -> `pc`=8000_0020.
- Pending trap, then new redirect with `pc_add_en`=0 -> redirect dropped; advance goes to `mtvec`.
- Redirect to 8000_0102 -> `pc`=8000_0100, `misalign_err`=1 held. Pc at FFFF_FFFC + advance -> 0000_0000. `sys_rst`=0 mid-pend -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter feeding instruction fetch; latches execute-side redirect/trap/mret requests until the next advance.
// Latency: pc/mepc update on the edge sampling pc_add_en=1 and are visible the next cycle; a same-cycle request takes effect at that edge.
// Backpressure: none; requests arriving without pc_add_en are held in a one-entry pending latch, and lower-priority arrivals are dropped.
//
// Ports:
//   sys_clk, sys_rst          clock, asynchronous active-low reset
//   pc_add_en                 advance strobe from fetch (one per completed instruction)
//   redir_valid/redir_target  taken branch/jump request and target
//   trap_valid/mtvec          trap entry request and vector base
//   mret_valid                return-from-trap request (target is mepc)
//   pc, mepc                  current PC and saved trap PC (registered)
//   pend_valid                a latched request is waiting for an advance
//   misalign_err              sticky flag: a selected target had bits [1:0] != 0
//   retire_cnt                64-bit retired-instruction count (only with PC_UNIT_RETIRE_CNT_EN)
//
// Optional feature macro: PC_UNIT_RETIRE_CNT_EN
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pc_add_en,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        trap_valid,
    input  logic [31:0] mtvec,
    input  logic        mret_valid,
    output logic [31:0] pc,
    output logic [31:0] mepc,
    output logic        pend_valid,
    output logic        misalign_err
`ifdef PC_UNIT_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);

    // Encoding doubles as priority: a larger value wins.
    typedef enum logic [1:0] {
        K_NONE  = 2'd0,
        K_REDIR = 2'd1,
        K_MRET  = 2'd2,
        K_TRAP  = 2'd3
    } kind_t;

    kind_t       pend_kind;
    logic [31:0] pend_target;

    kind_t       new_kind;
    logic [31:0] new_target;
    kind_t       sel_kind;
    logic [31:0] sel_target;
    logic        latch_new;
    logic        misalign_hit;
    logic [31:0] pc_next;
    logic [31:0] mepc_next;

    // The pending latch is empty exactly when its kind is NONE.
    assign pend_valid = (pend_kind != K_NONE);

    // Same-cycle request decode, highest priority first.
    always_comb begin
        new_kind   = K_NONE;
        new_target = 32'h0;
        if (trap_valid) begin
            new_kind   = K_TRAP;
            new_target = mtvec;
        end else if (mret_valid) begin
            new_kind   = K_MRET;
            new_target = mepc;
        end else if (redir_valid) begin
            new_kind   = K_REDIR;
            new_target = redir_target;
        end
    end

    // An idle-cycle request replaces the pending one when its priority is at
    // least as high; an empty latch (K_NONE) always accepts.
    assign latch_new = !pc_add_en && (new_kind != K_NONE) && (new_kind >= pend_kind);

    // On an advance a same-cycle request beats anything pending, even a
    // higher-priority one. A pending mret reads mepc at the advance itself.
    always_comb begin
        sel_kind   = K_NONE;
        sel_target = 32'h0;
        if (new_kind != K_NONE) begin
            sel_kind   = new_kind;
            sel_target = new_target;
        end else if (pend_kind != K_NONE) begin
            sel_kind   = pend_kind;
            sel_target = (pend_kind == K_MRET) ? mepc : pend_target;
        end
    end

    always_comb begin
        pc_next      = pc + 32'd4;
        mepc_next    = mepc;
        misalign_hit = 1'b0;
        if (sel_kind != K_NONE) begin
            // Low bits are forced to zero; the misalignment is only reported.
            pc_next      = {sel_target[31:2], 2'b00};
            misalign_hit = (sel_target[1:0] != 2'b00);
        end
        if (sel_kind == K_TRAP) begin
            mepc_next = pc;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pc           <= RESET_PC;
            mepc         <= 32'h0;
            pend_kind    <= K_NONE;
            pend_target  <= 32'h0;
            misalign_err <= 1'b0;
        end else if (pc_add_en) begin
            pc          <= pc_next;
            mepc        <= mepc_next;
            pend_kind   <= K_NONE;
            pend_target <= 32'h0;
            if (misalign_hit) begin
                misalign_err <= 1'b1;
            end
        end else if (latch_new) begin
            pend_kind   <= new_kind;
            pend_target <= new_target;
        end
    end

`ifdef PC_UNIT_RETIRE_CNT_EN
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            retire_cnt <= 64'h0;
        end else if (pc_add_en) begin
            retire_cnt <= retire_cnt + 64'd1;
        end
    end
`endif

endmodule
